// File: rtl/musa_ctrl_pkg.sv
// Shared encodings for the MUSA main control unit: opcodes, functs, select enums,
// FSM states and the packed datapath control bundle.
package musa_ctrl_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b000001;
    localparam logic [5:0] OP_SUBI   = 6'b000010;
    localparam logic [5:0] OP_ANDI   = 6'b000011;
    localparam logic [5:0] OP_ORI    = 6'b000100;
    localparam logic [5:0] OP_LW     = 6'b000101;
    localparam logic [5:0] OP_SW     = 6'b000110;
    localparam logic [5:0] OP_CMP    = 6'b000111;
    localparam logic [5:0] OP_JPC    = 6'b001000;
    localparam logic [5:0] OP_BRFL   = 6'b001001;
    localparam logic [5:0] OP_JR     = 6'b001010;
    localparam logic [5:0] OP_CALL   = 6'b001011;
    localparam logic [5:0] OP_RET    = 6'b001100;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOT  = 6'b100111;
    localparam logic [5:0] FN_NOP  = 6'b000000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic [2:0] {
        ALU_ADDR  = 3'b000,
        ALU_RTYPE = 3'b010,
        ALU_IMM   = 3'b011,
        ALU_BRFL  = 3'b101,
        ALU_CMP   = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_NONE = 2'b00,
        SRC_A_REG  = 2'b10
    } data_a_s_t;

    typedef enum logic [1:0] {
        SRC_B_IMM = 2'b00,
        SRC_B_REG = 2'b01,
        SRC_B_PC  = 2'b10
    } data_b_s_t;

    typedef enum logic [2:0] {
        PC_STACK = 3'b000,
        PC_REG   = 3'b001,
        PC_SEQ   = 3'b010,
        PC_JUMP  = 3'b011,
        PC_HALT  = 3'b100
    } pc_src_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_MD_WAIT,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic      reg_dst;
        logic      mem_read;
        logic      mem_to_reg;
        logic      mem_write;
        logic      reg_write;
        logic      push;
        logic      pop;
        alu_op_t   alu_op;
        data_a_s_t data_a_s;
        data_b_s_t data_b_s;
        pc_src_t   pc_src;
    } ctrl_bundle_t;

endpackage

// File: rtl/musa_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to control bundle plus the
// class flags the sequencer branches on.
module musa_ctrl_decode
    import musa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output ctrl_bundle_t          ctrl_o,
    output logic                  is_mem_o,
    output logic                  is_md_o,
    output logic                  is_halt_o,
    output logic                  is_illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instruction_i[DATA_WIDTH-1 -: 6];
    assign funct         = instruction_i[5:0];
    assign unused_fields = ^instruction_i[DATA_WIDTH-7:6];

    always_comb begin
        ctrl_o        = '0;
        ctrl_o.pc_src = PC_SEQ;
        is_mem_o      = 1'b0;
        is_md_o       = 1'b0;
        is_halt_o     = 1'b0;
        is_illegal_o  = 1'b0;
        case (opcode)
            OP_R_TYPE: begin
                if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOT, FN_NOP, FN_MULT, FN_DIV}) begin
                    ctrl_o.reg_dst   = 1'b1;
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = ALU_RTYPE;
                    ctrl_o.data_a_s  = SRC_A_REG;
                    ctrl_o.data_b_s  = SRC_B_REG;
                    is_md_o          = (funct == FN_MULT) || (funct == FN_DIV);
                end else begin
                    is_illegal_o = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_IMM;
                ctrl_o.data_a_s  = SRC_A_REG;
            end
            OP_LW: begin
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.data_a_s   = SRC_A_REG;
                is_mem_o          = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.data_a_s  = SRC_A_REG;
                is_mem_o         = 1'b1;
            end
            OP_CMP: begin
                ctrl_o.alu_op   = ALU_CMP;
                ctrl_o.data_a_s = SRC_A_REG;
                ctrl_o.data_b_s = SRC_B_REG;
            end
            OP_JPC: begin
                ctrl_o.data_b_s = SRC_B_PC;
                ctrl_o.pc_src   = PC_JUMP;
            end
            OP_BRFL: begin
                ctrl_o.alu_op   = ALU_BRFL;
                ctrl_o.data_a_s = SRC_A_REG;
                ctrl_o.pc_src   = PC_REG;
            end
            OP_JR:   ctrl_o.pc_src = PC_REG;
            OP_CALL: begin
                ctrl_o.push   = 1'b1;
                ctrl_o.pc_src = PC_REG;
            end
            OP_RET: begin
                ctrl_o.pop    = 1'b1;
                ctrl_o.pc_src = PC_STACK;
            end
            OP_HALT: begin
                ctrl_o.pc_src = PC_HALT;
                is_halt_o     = 1'b1;
            end
            // Unknown opcodes fall through as a NOP so the commit still retires them.
            default: is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/musa_control_fsm.sv
// Multi-cycle main control unit of the MUSA core: fetch handshake, registered
// control bundle, memory / mult-div wait sequencing with timeouts, commit strobe.
//
// state      | meaning
// FETCH      | ready for an instruction, bundle cleared
// DECODE     | IR latched, bundle registered at exit
// EXEC       | bundle visible, illegal / md_start pulses
// MEM        | waiting for mem_ack, bounded by MEM_WAIT_MAX
// MD_WAIT    | waiting for md_done, bounded by MD_WAIT_MAX
// WB         | single-cycle commit
// HALT       | absorbing until reset
module musa_control_fsm
    import musa_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WAIT_MAX = 15,
    parameter int MD_WAIT_MAX  = 63
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  mem_ack_i,
    input  logic                  md_done_i,
    output logic                  md_start_o,
    output logic                  reg_dst_o,
    output logic                  mem_read_o,
    output logic                  mem_to_reg_o,
    output logic                  mem_write_o,
    output logic                  reg_write_o,
    output logic                  push_o,
    output logic                  pop_o,
    output logic [2:0]            alu_op_o,
    output logic [1:0]            data_a_s_o,
    output logic [1:0]            data_b_s_o,
    output logic [2:0]            pc_src_o,
    output logic                  commit_o,
    output logic                  illegal_o,
    output logic                  bus_err_o,
    output logic                  halted_o
);

    localparam int CNT_W = $clog2(((MEM_WAIT_MAX > MD_WAIT_MAX) ? MEM_WAIT_MAX : MD_WAIT_MAX) + 1);
    localparam logic [CNT_W-1:0] MEM_LIM = CNT_W'(MEM_WAIT_MAX);
    localparam logic [CNT_W-1:0] MD_LIM  = CNT_W'(MD_WAIT_MAX);

    state_t                state_q, state_d;
    ctrl_bundle_t          bundle_q, bundle_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ir_q;

    ctrl_bundle_t dec_ctrl;
    logic         dec_mem, dec_md, dec_halt, dec_illegal;

    musa_ctrl_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
        .instruction_i (ir_q),
        .ctrl_o        (dec_ctrl),
        .is_mem_o      (dec_mem),
        .is_md_o       (dec_md),
        .is_halt_o     (dec_halt),
        .is_illegal_o  (dec_illegal)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_FETCH;
            bundle_q <= '0;
            cnt_q    <= '0;
            ir_q     <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
            cnt_q    <= cnt_d;
            if (instr_ready_o && instr_valid_i) ir_q <= instruction_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        bundle_d      = bundle_q;
        cnt_d         = cnt_q;
        instr_ready_o = 1'b0;
        md_start_o    = 1'b0;
        commit_o      = 1'b0;
        illegal_o     = 1'b0;
        bus_err_o     = 1'b0;
        halted_o      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                bundle_d = dec_ctrl;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                illegal_o = dec_illegal;
                cnt_d     = '0;
                if (dec_mem) begin
                    state_d = ST_MEM;
                end else if (dec_md) begin
                    md_start_o = 1'b1;
                    state_d    = ST_MD_WAIT;
                end else if (dec_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // The strobes drop once the access completes; the rest of the bundle
                // stays up for the writeback.
                if (mem_ack_i) begin
                    bundle_d.mem_read  = 1'b0;
                    bundle_d.mem_write = 1'b0;
                    state_d            = ST_WB;
                end else if (cnt_q == MEM_LIM) begin
                    bus_err_o = 1'b1;
                    bundle_d  = '0;
                    state_d   = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MD_WAIT: begin
                if (md_done_i) begin
                    state_d = ST_WB;
                end else if (cnt_q == MD_LIM) begin
                    bus_err_o = 1'b1;
                    bundle_d  = '0;
                    state_d   = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                commit_o = 1'b1;
                bundle_d = '0;
                state_d  = ST_FETCH;
            end
            ST_HALT: halted_o = 1'b1;
            default: begin
                bundle_d = '0;
                state_d  = ST_FETCH;
            end
        endcase
    end

    assign reg_dst_o    = bundle_q.reg_dst;
    assign mem_read_o   = bundle_q.mem_read;
    assign mem_to_reg_o = bundle_q.mem_to_reg;
    assign mem_write_o  = bundle_q.mem_write;
    assign reg_write_o  = bundle_q.reg_write;
    assign push_o       = bundle_q.push;
    assign pop_o        = bundle_q.pop;
    assign alu_op_o     = bundle_q.alu_op;
    assign data_a_s_o   = bundle_q.data_a_s;
    assign data_b_s_o   = bundle_q.data_b_s;
    assign pc_src_o     = bundle_q.pc_src;

endmodule

// File: tb/tb_musa_control_fsm.sv
// Self-checking bench for musa_control_fsm: per-instruction timeline model compared
// every cycle, plus literal spot checks of the documented scenarios.
module tb_musa_control_fsm;

    typedef struct packed {
        logic       instr_ready;
        logic       md_start;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       push;
        logic       pop;
        logic [2:0] alu_op;
        logic [1:0] a_s;
        logic [1:0] b_s;
        logic [2:0] pc_src;
        logic       commit;
        logic       illegal;
        logic       bus_err;
        logic       halted;
    } outs_t;

    localparam int HMAX = 40000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0, mem_ack = 1'b0, md_done = 1'b0;
    logic        instr_ready, md_start, reg_dst, mem_read, mem_to_reg, mem_write;
    logic        reg_write, push, pop, commit, illegal, bus_err, halted;
    logic [2:0]  alu_op, pc_src;
    logic [1:0]  data_a_s, data_b_s;

    outs_t act, exp_o, idle_o;
    bit    exp_en = 1'b0;
    int    errors = 0, checks = 0, cyc = 0;
    outs_t hist [HMAX];
    logic [5:0] fn_list [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100111, 6'b000000, 6'b011000, 6'b011010};

    musa_control_fsm dut (
        .clk_i(clk), .rst_ni(rst_n), .instruction_i(instruction),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .mem_ack_i(mem_ack), .md_done_i(md_done), .md_start_o(md_start),
        .reg_dst_o(reg_dst), .mem_read_o(mem_read), .mem_to_reg_o(mem_to_reg),
        .mem_write_o(mem_write), .reg_write_o(reg_write), .push_o(push), .pop_o(pop),
        .alu_op_o(alu_op), .data_a_s_o(data_a_s), .data_b_s_o(data_b_s),
        .pc_src_o(pc_src), .commit_o(commit), .illegal_o(illegal),
        .bus_err_o(bus_err), .halted_o(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        act = '0;
        act.instr_ready = instr_ready; act.md_start = md_start; act.reg_dst = reg_dst;
        act.mem_read = mem_read; act.mem_to_reg = mem_to_reg; act.mem_write = mem_write;
        act.reg_write = reg_write; act.push = push; act.pop = pop; act.alu_op = alu_op;
        act.a_s = data_a_s; act.b_s = data_b_s; act.pc_src = pc_src; act.commit = commit;
        act.illegal = illegal; act.bus_err = bus_err; act.halted = halted;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HMAX) hist[cyc] <= act;
        if (exp_en) begin
            checks++;
            if (act !== exp_o) begin
                errors++;
                $display("FAIL cycle_outputs cyc=%0d actual=%h expected=%h", cyc, act, exp_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        instr_valid = 1'($urandom);
        instruction = $urandom;
        mem_ack     = 1'($urandom);
        md_done     = 1'($urandom);
    endtask

    // Control bundle straight from the decode table.
    function automatic outs_t model_bundle(input logic [31:0] ins);
        outs_t o;
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        o = '0;
        o.pc_src = 3'b010;
        case (op)
            6'b000000: if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                      6'b100111, 6'b000000, 6'b011000, 6'b011010}) begin
                o.reg_dst = 1; o.reg_write = 1; o.alu_op = 3'b010; o.a_s = 2'b10; o.b_s = 2'b01;
            end
            6'b000001, 6'b000010, 6'b000011, 6'b000100: begin
                o.reg_write = 1; o.alu_op = 3'b011; o.a_s = 2'b10;
            end
            6'b000101: begin o.mem_read = 1; o.mem_to_reg = 1; o.reg_write = 1; o.a_s = 2'b10; end
            6'b000110: begin o.mem_write = 1; o.a_s = 2'b10; end
            6'b000111: begin o.alu_op = 3'b110; o.a_s = 2'b10; o.b_s = 2'b01; end
            6'b001000: begin o.b_s = 2'b10; o.pc_src = 3'b011; end
            6'b001001: begin o.alu_op = 3'b101; o.a_s = 2'b10; o.pc_src = 3'b001; end
            6'b001010: o.pc_src = 3'b001;
            6'b001011: begin o.push = 1; o.pc_src = 3'b001; end
            6'b001100: begin o.pop = 1; o.pc_src = 3'b000; end
            6'b111111: o.pc_src = 3'b100;
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit model_illegal(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'b000000)
            return !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100111, 6'b000000, 6'b011000, 6'b011010});
        return !((op <= 6'b001100) || (op == 6'b111111));
    endfunction

    // 0: plain, 1: memory, 2: mult/div, 3: halt
    function automatic int model_kind(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'b000101 || op == 6'b000110) return 1;
        if (op == 6'b000000 && (fn == 6'b011000 || fn == 6'b011010)) return 2;
        if (op == 6'b111111) return 3;
        return 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] op, fn;
        int r;
        r = $urandom_range(0, 15);
        op = (r < 13) ? 6'(r) : 6'($urandom_range(13, 62));
        r = $urandom_range(0, 9);
        fn = (r < 8) ? fn_list[r] : 6'($urandom);
        return {op, 20'($urandom), fn};
    endfunction

    // dly: wait-state index at which ack/done arrives, -1 for never.
    task automatic run_instr(input logic [31:0] ins, input int dly, input int idle, output int t_xfer);
        outs_t b;
        int kind, lim;
        b = model_bundle(ins);
        kind = model_kind(ins);
        for (int i = 0; i < idle; i++) begin
            step(); noise(); instr_valid = 1'b0; exp_o = idle_o;
        end
        step(); noise(); instruction = ins; instr_valid = 1'b1; exp_o = idle_o;
        t_xfer = cyc;
        step(); noise(); exp_o = '0;
        step(); noise(); exp_o = b; exp_o.illegal = model_illegal(ins); exp_o.md_start = (kind == 2);
        case (kind)
            0: begin step(); noise(); exp_o = b; exp_o.commit = 1'b1; end
            3: repeat (20) begin step(); noise(); exp_o = b; exp_o.halted = 1'b1; end
            default: begin
                lim = (kind == 1) ? 15 : 63;
                for (int i = 0; i <= lim; i++) begin
                    step(); noise();
                    if (kind == 1) mem_ack = (i == dly); else md_done = (i == dly);
                    exp_o = b;
                    if (i == dly) begin
                        step(); noise();
                        exp_o = b; exp_o.mem_read = 1'b0; exp_o.mem_write = 1'b0; exp_o.commit = 1'b1;
                        break;
                    end
                    if (i == lim) exp_o.bus_err = 1'b1;
                end
            end
        endcase
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_addi, t_lw, t_mult, t_sw, t_ill, t_halt, t_div, t_post, t_tmp, dly, k;
        logic [31:0] ins;
        logic any_commit;
        outs_t b_div;

        idle_o = '0;
        idle_o.instr_ready = 1'b1;
        exp_o  = idle_o;
        exp_en = 1'b1;
        repeat (3) step();
        chk("reset_outputs", 32'(act), 32'(idle_o));
        chk("reset_ready", 32'(instr_ready), 32'd1);
        rst_n = 1'b1;

        run_instr(32'h0420_0005, 0, 1, t_addi);
        run_instr(32'h1441_0004, 2, 0, t_lw);
        run_instr(32'h0062_2018, 9, 0, t_mult);
        run_instr(32'h1862_0008, -1, 0, t_sw);

        for (int n = 0; n < 150; n++) begin
            ins = rand_instr();
            k = model_kind(ins);
            dly = 0;
            if (k == 1) begin dly = $urandom_range(0, 17); if (dly > 15) dly = -1; end
            if (k == 2) begin dly = $urandom_range(0, 70); if (dly > 63) dly = -1; end
            run_instr(ins, dly, $urandom_range(0, 2), t_tmp);
        end

        // DIV interrupted by reset while waiting on the divider
        b_div = model_bundle(32'h0062_201A);
        step(); noise(); instruction = 32'h0062_201A; instr_valid = 1'b1; mem_ack = 0; md_done = 0;
        exp_o = idle_o; t_div = cyc;
        step(); noise(); md_done = 0; exp_o = '0;
        step(); noise(); md_done = 0; exp_o = b_div; exp_o.md_start = 1'b1;
        step(); noise(); md_done = 0; exp_o = b_div;
        step(); noise(); md_done = 0; exp_o = b_div;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(act), 32'(idle_o));
        chk("async_reset_no_commit", 32'(commit), 32'd0);
        exp_o = idle_o;
        step(); noise(); instr_valid = 1'b0;
        step(); noise(); instr_valid = 1'b0; rst_n = 1'b1;
        run_instr(32'h0420_0005, 0, 0, t_post);

        run_instr(32'hCC00_0000, 0, 0, t_ill);
        run_instr(32'hFC00_0000, 0, 0, t_halt);
        @(negedge clk);
        #1;
        exp_en = 1'b0;

        chk("addi_reg_write_T2", 32'(hist[t_addi+2].reg_write), 32'd1);
        chk("addi_sel_T2", {26'd0, hist[t_addi+2].a_s, hist[t_addi+2].b_s, hist[t_addi+2].pc_src[1:0]}, 32'b10_00_10);
        chk("addi_pc_src_T2", 32'(hist[t_addi+2].pc_src), 32'd2);
        chk("addi_commit_T2", 32'(hist[t_addi+2].commit), 32'd0);
        chk("addi_commit_T3", 32'(hist[t_addi+3].commit), 32'd1);
        chk("addi_ready_T4", 32'(hist[t_addi+4].instr_ready), 32'd1);
        chk("lw_bundle_T2", {29'd0, hist[t_lw+2].mem_read, hist[t_lw+2].mem_to_reg, hist[t_lw+2].reg_write}, 32'b111);
        chk("lw_mem_read_T5", 32'(hist[t_lw+5].mem_read), 32'd1);
        chk("lw_mem_read_T6", 32'(hist[t_lw+6].mem_read), 32'd0);
        chk("lw_commit_T6", 32'(hist[t_lw+6].commit), 32'd1);
        chk("lw_commit_T5", 32'(hist[t_lw+5].commit), 32'd0);
        chk("mult_md_start_T2", 32'(hist[t_mult+2].md_start), 32'd1);
        chk("mult_md_start_T3", 32'(hist[t_mult+3].md_start), 32'd0);
        chk("mult_alu_op_T12", 32'(hist[t_mult+12].alu_op), 32'd2);
        chk("mult_reg_dst_T12", 32'(hist[t_mult+12].reg_dst), 32'd1);
        chk("mult_commit_T13", 32'(hist[t_mult+13].commit), 32'd1);
        chk("sw_bus_err_T17", 32'(hist[t_sw+17].bus_err), 32'd0);
        chk("sw_bus_err_T18", 32'(hist[t_sw+18].bus_err), 32'd1);
        any_commit = 1'b0;
        for (int i = t_sw; i <= t_sw + 19; i++) any_commit |= hist[i].commit;
        chk("sw_no_commit", 32'(any_commit), 32'd0);
        chk("sw_ready_T19", 32'(hist[t_sw+19].instr_ready), 32'd1);
        any_commit = 1'b0;
        for (int i = t_div; i <= t_div + 6; i++) any_commit |= hist[i].commit;
        chk("div_reset_no_commit", 32'(any_commit), 32'd0);
        chk("post_reset_commit", 32'(hist[t_post+3].commit), 32'd1);
        chk("illegal_pulse_T2", 32'(hist[t_ill+2].illegal), 32'd1);
        chk("illegal_pulse_T3", 32'(hist[t_ill+3].illegal), 32'd0);
        chk("illegal_writes", {28'd0, hist[t_ill+2].reg_write, hist[t_ill+2].mem_write, hist[t_ill+2].push, hist[t_ill+2].pop}, 32'd0);
        chk("illegal_pc_src", 32'(hist[t_ill+2].pc_src), 32'd2);
        chk("illegal_commit_T3", 32'(hist[t_ill+3].commit), 32'd1);
        chk("halt_halted", 32'(hist[t_halt+22].halted), 32'd1);
        chk("halt_pc_src", 32'(hist[t_halt+22].pc_src), 32'd4);
        chk("halt_ready", 32'(hist[t_halt+22].instr_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
